// File: rtl/slice_scheduler.sv
// rtl/slice_scheduler.sv - slice phase sequencer driving DCT, DC VLC and AC VLC
// Optional feature macro: SLICE_SCHED_BLKCHK_EN (reject block_num == 0 or > MAX_BLOCKS)
// Ports:
//   clock, reset_n              : single clock, asynchronous active-low reset
//   slice_start, block_num      : slice request and its block count
//   slice_ready                 : 1 while a slice_start will be accepted (IDLE)
//   dc_vlc_reset, ac_vlc_reset  : 0 holds the VLC engine in reset, 1 lets it run
//   phase, phase_count          : current phase and cycles spent in it
//   slice_done                  : one-cycle pulse in DONE
//   start_dropped               : one-cycle pulse after a slice_start seen while busy
//   blk_err                     : one-cycle pulse after a rejected block_num
module slice_scheduler #(
  parameter int unsigned DCT_TIME     = 12,
  parameter int unsigned DC_VLC_TIME  = 45,
  parameter int unsigned AC_PER_BLOCK = 63,
  parameter int unsigned AC_TAIL      = 5,
  parameter int unsigned MAX_BLOCKS   = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        slice_start,
  input  logic [31:0] block_num,
  output logic        slice_ready,
  output logic        dc_vlc_reset,
  output logic        ac_vlc_reset,
  output logic [2:0]  phase,
  output logic [31:0] phase_count,
  output logic        slice_done,
  output logic        start_dropped,
  output logic        blk_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DCT    = 3'd1,
    DC_VLC = 3'd2,
    AC_VLC = 3'd3,
    DONE   = 3'd4
  } phase_t;

  localparam logic [31:0] DCT_TIME_W     = 32'(DCT_TIME);
  localparam logic [31:0] DC_VLC_TIME_W  = 32'(DC_VLC_TIME);
  localparam logic [31:0] AC_PER_BLOCK_W = 32'(AC_PER_BLOCK);
  localparam logic [31:0] AC_TAIL_W      = 32'(AC_TAIL);
  localparam logic [31:0] MAX_BLOCKS_W   = 32'(MAX_BLOCKS);

  phase_t      phase_q, phase_d;
  logic [31:0] count_q, count_d;
  logic [31:0] blk_q, blk_d;
  logic        slice_ready_q, slice_ready_d;
  logic        dc_vlc_reset_q, dc_vlc_reset_d;
  logic        ac_vlc_reset_q, ac_vlc_reset_d;
  logic        slice_done_q, slice_done_d;
  logic        start_dropped_q, start_dropped_d;
  logic        blk_err_q, blk_err_d;

  // Phase lengths depend only on the latched block count, so they stay
  // fixed for the whole slice regardless of later block_num activity.
  logic [31:0] dct_len;
  logic [31:0] ac_len;

`ifndef SLICE_SCHED_BLKCHK_EN
  // MAX_BLOCKS only matters when the block-count check is built in.
  logic unused_max_blocks;
  assign unused_max_blocks = ^MAX_BLOCKS_W;
`endif

  always_comb begin
    phase_d         = phase_q;
    count_d         = count_q + 32'd1;
    blk_d           = blk_q;
    start_dropped_d = 1'b0;
    blk_err_d       = 1'b0;
    dct_len         = DCT_TIME_W + blk_q;
    ac_len          = (AC_PER_BLOCK_W * blk_q) + AC_TAIL_W;

    case (phase_q)
      IDLE: begin
        if (slice_start) begin
`ifdef SLICE_SCHED_BLKCHK_EN
          if ((block_num == 32'd0) || (block_num > MAX_BLOCKS_W)) begin
            blk_err_d = 1'b1;
          end else begin
            phase_d = DCT;
            blk_d   = block_num;
          end
`else
          phase_d = DCT;
          blk_d   = block_num;
`endif
        end
      end
      // A zero-length phase wraps the compare to 2^32-1, so the phase is
      // still visited rather than skipped.
      DCT:     if (count_q == dct_len - 32'd1)       phase_d = DC_VLC;
      DC_VLC:  if (count_q == DC_VLC_TIME_W - 32'd1) phase_d = AC_VLC;
      AC_VLC:  if (count_q == ac_len - 32'd1)        phase_d = DONE;
      DONE:    phase_d = IDLE;
      default: phase_d = IDLE;
    endcase

    if (slice_start && (phase_q != IDLE)) begin
      start_dropped_d = 1'b1;
    end

    if (phase_d != phase_q) begin
      count_d = 32'd0;
    end

    // Status outputs are decoded from the next phase and registered.
    slice_ready_d  = (phase_d == IDLE);
    dc_vlc_reset_d = (phase_d == DC_VLC) || (phase_d == AC_VLC);
    ac_vlc_reset_d = (phase_d == AC_VLC);
    slice_done_d   = (phase_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q         <= IDLE;
      count_q         <= 32'd0;
      blk_q           <= 32'd0;
      slice_ready_q   <= 1'b1;
      dc_vlc_reset_q  <= 1'b0;
      ac_vlc_reset_q  <= 1'b0;
      slice_done_q    <= 1'b0;
      start_dropped_q <= 1'b0;
      blk_err_q       <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      count_q         <= count_d;
      blk_q           <= blk_d;
      slice_ready_q   <= slice_ready_d;
      dc_vlc_reset_q  <= dc_vlc_reset_d;
      ac_vlc_reset_q  <= ac_vlc_reset_d;
      slice_done_q    <= slice_done_d;
      start_dropped_q <= start_dropped_d;
      blk_err_q       <= blk_err_d;
    end
  end

  assign phase         = phase_q;
  assign phase_count   = count_q;
  assign slice_ready   = slice_ready_q;
  assign dc_vlc_reset  = dc_vlc_reset_q;
  assign ac_vlc_reset  = ac_vlc_reset_q;
  assign slice_done    = slice_done_q;
  assign start_dropped = start_dropped_q;
`ifdef SLICE_SCHED_BLKCHK_EN
  assign blk_err       = blk_err_q;
`else
  assign blk_err       = 1'b0;
  logic unused_blk_err;
  assign unused_blk_err = blk_err_q;
`endif

endmodule

// File: tb/tb_slice_scheduler.sv
// tb/tb_slice_scheduler.sv - scoreboard bench for slice_scheduler
module tb_slice_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        slice_start;
  logic [31:0] block_num;
  logic        slice_ready;
  logic        dc_vlc_reset;
  logic        ac_vlc_reset;
  logic [2:0]  phase;
  logic [31:0] phase_count;
  logic        slice_done;
  logic        start_dropped;
  logic        blk_err;

  slice_scheduler dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .slice_start   (slice_start),
    .block_num     (block_num),
    .slice_ready   (slice_ready),
    .dc_vlc_reset  (dc_vlc_reset),
    .ac_vlc_reset  (ac_vlc_reset),
    .phase         (phase),
    .phase_count   (phase_count),
    .slice_done    (slice_done),
    .start_dropped (start_dropped),
    .blk_err       (blk_err)
  );

  always #5 clock = ~clock;

  // Number of rising edges seen so far; while driving between edges this
  // is also the index of the edge that will sample the new inputs.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int drop_cnt = 0;
  int err_cnt = 0;

  // fl = {dc_vlc_reset, ac_vlc_reset, slice_ready, slice_done, start_dropped, blk_err}
  typedef struct {
    int          cyc;
    logic [2:0]  ph;
    logic [31:0] cnt;
    bit          cnt_en;
    logic [5:0]  fl;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int c, input logic [2:0] ph, input int cnt,
                               input bit cnt_en, input logic [5:0] fl);
    exp_t x;
    x.cyc    = c;
    x.ph     = ph;
    x.cnt    = 32'(cnt);
    x.cnt_en = cnt_en;
    x.fl     = fl;
    sb.push_back(x);
  endfunction

  // Expected checkpoints for a slice accepted on edge e with n blocks.
  // held: slice_start stays high while the slice runs.
  task automatic push_slice(input int e, input int n, input bit held);
    int ld, la, t;
    logic h;
    ld = 12 + n;
    la = 63 * n + 5;
    t  = e + ld + 45 + la;
    h  = held;
    push(e,           3'd1, 0,      1, 6'b000000);
    push(e + ld - 1,  3'd1, ld - 1, 1, {4'b0000, h, 1'b0});
    push(e + ld,      3'd2, 0,      1, {4'b1000, h, 1'b0});
    push(e + ld + 44, 3'd2, 44,     1, {4'b1000, h, 1'b0});
    push(e + ld + 45, 3'd3, 0,      1, {4'b1100, h, 1'b0});
    push(t - 1,       3'd3, la - 1, 1, {4'b1100, h, 1'b0});
    push(t,           3'd4, 0,      1, {4'b0001, h, 1'b0});
    push(t + 1,       3'd0, 0,      1, {4'b0010, h, 1'b0});
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (start_dropped) drop_cnt++;
      if (blk_err) err_cnt++;
      while (sb.size() > 0 && sb[0].cyc <= cyc - 1) begin
        exp_t x;
        x = sb.pop_front();
        if (x.cyc != cyc - 1)
          check($sformatf("late@%0d", x.cyc), 64'(cyc - 1), 64'(x.cyc));
        check($sformatf("outs@%0d", x.cyc),
              64'({phase, dc_vlc_reset, ac_vlc_reset, slice_ready, slice_done, start_dropped, blk_err}),
              64'({x.ph, x.fl}));
        if (x.cnt_en)
          check($sformatf("cnt@%0d", x.cyc), 64'(phase_count), 64'(x.cnt));
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_slice(input int n);
    int e;
    e = cyc;
    slice_start = 1'b1;
    block_num   = 32'(n);
    push_slice(e, n, 1'b0);
    tick();
    slice_start = 1'b0;
    wait_drain(3000);
    tick();
  endtask

  initial begin
    int e;
    int d0;
    reset_n     = 1'b0;
    slice_start = 1'b0;
    block_num   = 32'd0;
    repeat (3) tick();

    check("rst_phase", 64'(phase), 64'd0);
    check("rst_cnt", 64'(phase_count), 64'd0);
    check("rst_outs", 64'({slice_ready, dc_vlc_reset, ac_vlc_reset, slice_done, start_dropped, blk_err}),
          64'(6'b100000));

    // First edge after reset release accepts; block_num changes mid-DCT are ignored.
    reset_n     = 1'b1;
    e           = cyc;
    slice_start = 1'b1;
    block_num   = 32'd4;
    push_slice(e, 4, 1'b0);
    tick();
    slice_start = 1'b0;
    block_num   = 32'd20;
    wait_drain(500);
    tick();

    // Back-to-back with slice_start held high.
    d0          = drop_cnt;
    e           = cyc;
    slice_start = 1'b1;
    block_num   = 32'd1;
    push_slice(e, 1, 1'b1);
    push_slice(e + 128, 1, 1'b0);
    while (cyc < e + 129) tick();
    slice_start = 1'b0;
    wait_drain(500);
    check("drop_pulses", 64'(drop_cnt - d0), 64'd127);
    tick();

    // Reset asserted in the middle of AC_VLC.
    e           = cyc;
    slice_start = 1'b1;
    block_num   = 32'd8;
    tick();
    slice_start = 1'b0;
    while (cyc < e + 100) tick();
    check("pre_rst_phase", 64'({phase, dc_vlc_reset, ac_vlc_reset}), 64'({3'd3, 2'b11}));
    reset_n = 1'b0;
    #1;
    check("mid_rst_phase", 64'(phase), 64'd0);
    check("mid_rst_cnt", 64'(phase_count), 64'd0);
    check("mid_rst_outs", 64'({slice_ready, dc_vlc_reset, ac_vlc_reset, slice_done}), 64'(4'b1000));
    tick();
    reset_n = 1'b1;
    run_slice(8);

    run_slice(2);
    run_slice(7);

`ifdef SLICE_SCHED_BLKCHK_EN
    e           = cyc;
    slice_start = 1'b1;
    block_num   = 32'd0;
    push(e, 3'd0, 0, 0, 6'b001001);
    tick();
    block_num   = 32'd33;
    push(e + 1, 3'd0, 0, 0, 6'b001001);
    tick();
    slice_start = 1'b0;
    push(e + 2, 3'd0, 0, 0, 6'b001000);
    wait_drain(10);
    tick();
    run_slice(32);
    check("blk_err_pulses", 64'(err_cnt), 64'd2);
`else
    run_slice(0);
    check("blk_err_pulses", 64'(err_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 Parameter DCT_TIME, default 12: fixed DCT-phase cycles added to block count.
REQ-002 Parameter DC_VLC_TIME, default 45: DC VLC phase length in cycles.
REQ-003 Parameter AC_PER_BLOCK, default 63: AC VLC cycles per block.
REQ-004 Parameter AC_TAIL, default 5: extra AC VLC drain cycles.
REQ-005 Parameter MAX_BLOCKS, default 32: largest legal block_num.
REQ-006 Port clock  input  1  single clock; all state updates on rising edge.
REQ-007 Port reset_n  input  1  asynchronous active-low reset.
REQ-008 Port slice_start  input  1  slice request, sampled each rising edge.
REQ-009 Port block_num  input  32  blocks in requested slice, sampled with slice_start.
REQ-010 Port slice_ready  output  1  high when a slice_start will be accepted.
REQ-011 Port dc_vlc_reset  output  1  0 holds DC VLC in reset, 1 runs it.
REQ-012 Port ac_vlc_reset  output  1  0 holds AC VLC in reset, 1 runs it.
REQ-013 Port phase  output  3  current state encoding (IDLE=0, DCT=1, DC_VLC=2, AC_VLC=3, DONE=4).
REQ-014 Port phase_count  output  32  cycles elapsed in current phase, 0 on phase entry.
REQ-015 Port slice_done  output  1  one-cycle pulse in DONE.
REQ-016 Port start_dropped  output  1  one-cycle pulse when slice_start is seen while not ready.
REQ-017 Port blk_err  output  1  one-cycle pulse on rejected block_num (see Configuration).

Function
REQ-018 All outputs are registered; none is combinational from inputs.
REQ-019 Acceptance edge: slice_start=1 while phase=IDLE (and block_num legal if checked); block_num latched into internal blk_r; phase=DCT after that edge.
REQ-020 DCT: lasts DCT_TIME+blk_r cycles; dc_vlc_reset=0, ac_vlc_reset=0.
REQ-021 DC_VLC: lasts DC_VLC_TIME cycles; dc_vlc_reset=1, ac_vlc_reset=0.
REQ-022 AC_VLC: lasts AC_PER_BLOCK*blk_r+AC_TAIL cycles; dc_vlc_reset=1, ac_vlc_reset=1.
REQ-023 DONE: exactly 1 cycle; slice_done=1, dc_vlc_reset=0, ac_vlc_reset=0; then IDLE.
REQ-024 slice_ready=1 only in IDLE; slice_start in any other phase is ignored and pulses start_dropped the following cycle.
REQ-025 Phase lengths are computed in 32-bit unsigned arithmetic at acceptance and held constant for the slice; block_num changes mid-slice have no effect.
REQ-026 phase_count increments by 1 per cycle, wraps modulo 2^32, and clears to 0 on every phase transition.
REQ-027 No phase is ever skipped; with blk_r=0 (unchecked build) DCT lasts DCT_TIME and AC_VLC lasts AC_TAIL cycles.

Reset
REQ-028 reset_n=0 asynchronously forces phase=IDLE, phase_count=0, blk_r=0, slice_ready=1, all other outputs 0, including mid-slice.
REQ-029 First acceptance is possible on the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro SLICE_SCHED_BLKCHK_EN defined: slice_start in IDLE with block_num=0 or block_num>MAX_BLOCKS is rejected, phase stays IDLE, blk_err pulses 1 cycle.
REQ-031 Macro undefined: any block_num is accepted, blk_err is tied to 0.

Verification
REQ-032 block_num=4, start at edge 0 -> DCT after edges 0..15, dc_vlc_reset rises after edge 16, ac_vlc_reset rises after edge 61, slice_done=1 after edge 318 only, slice_ready=1 after edge 319.
REQ-033 block_num=1 back-to-back, slice_start held high -> second acceptance on the edge after DONE; start_dropped pulses on every non-IDLE cycle with slice_start=1.
REQ-034 reset_n pulsed low during AC_VLC of a block_num=8 slice -> immediately phase=0, both vlc resets 0, slice_ready=1; next start runs full-length slice.
REQ-035 block_num changed from 4 to 20 during DCT -> phase timings identical to REQ-032.
REQ-036 With SLICE_SCHED_BLKCHK_EN: block_num=0 and block_num=33 -> blk_err pulse, phase stays 0; block_num=32 -> AC_VLC lasts 2021 cycles.
REQ-037 Without macro: block_num=0 -> DCT 12, DC_VLC 45, AC_VLC 5 cycles, blk_err never 1.
